alu_reg4: RTL and testbench

- 4-bit ALU with a registered result and flags; the datapath core of the team's 4-bit processor.
- Selects one of five operations on operands a and b using a 3-bit function code f.
- Registers result y plus carry and zero flags on the rising clock edge.
- Feeds the accumulator and the flag register of the processor.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_core4.sv | 40 ++++
 rtl/alu_reg4.sv | 46 ++++
 tb/tb_alu_reg4.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width and function codes for the 4-bit ALU
package alu_pkg;
  localparam int WIDTH = 4;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;
endpackage

// File: rtl/alu_core4.sv
// rtl/alu_core4.sv - combinational ALU core producing next result and carry
module alu_core4
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [2:0]   f_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         carry_o
);
  logic [W:0] sum;

  always_comb begin
    sum     = '0;
    y_o     = '0;
    carry_o = 1'b0;
    unique case (f_i)
      ALU_PASS_A: y_o = a_i;
      ALU_SUB: begin
        // Two's-complement subtract; carry out is the no-borrow flag.
        sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
        y_o     = sum[W-1:0];
        carry_o = sum[W];
      end
      ALU_PASS_B: y_o = b_i;
      ALU_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        y_o     = sum[W-1:0];
        carry_o = sum[W];
      end
      ALU_NAND: y_o = ~(a_i & b_i);
      default: begin
        y_o     = '0;
        carry_o = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/alu_reg4.sv
// rtl/alu_reg4.sv - ALU with registered result, carry and zero flags
module alu_reg4
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   f,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         carry,
  output logic         zero,
  output logic [W-1:0] y
);
  logic [W-1:0] y_d, y_q;
  logic         carry_d, carry_q;
  logic         zero_d, zero_q;

  alu_core4 #(.W(W)) u_core (
    .f_i    (f),
    .a_i    (a),
    .b_i    (b),
    .y_o    (y_d),
    .carry_o(carry_d)
  );

  // Zero tracks the next result for every code, reserved codes included.
  assign zero_d = (y_d == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign y     = y_q;
  assign carry = carry_q;
  assign zero  = zero_q;
endmodule

// File: tb/tb_alu_reg4.sv
// tb/tb_alu_reg4.sv - self-checking bench for alu_reg4 against an arithmetic model
module tb_alu_reg4;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] f = 3'b000;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       carry, zero;
  logic [3:0] y;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_y;
  logic       exp_c, exp_z;

  always #5 clk = ~clk;

  alu_reg4 dut (
    .clk  (clk),
    .reset(reset),
    .f    (f),
    .a    (a),
    .b    (b),
    .carry(carry),
    .zero (zero),
    .y    (y)
  );

  task automatic model(input logic [2:0] ff, input logic [3:0] aa, input logic [3:0] bb);
    int ai, bi, r;
    ai = int'(aa);
    bi = int'(bb);
    r = 0;
    exp_c = 1'b0;
    case (ff)
      3'd0: r = ai;
      3'd1: begin
        exp_c = (ai >= bi);
        r = ai - bi;
        if (r < 0) r = r + 16;
      end
      3'd2: r = bi;
      3'd3: begin
        r = ai + bi;
        exp_c = (r >= 16);
        r = r % 16;
      end
      3'd4: r = 15 - (ai & bi);
      default: r = 0;
    endcase
    exp_y = r[3:0];
    exp_z = (r == 0);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ey, input logic ec, input logic ez);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".carry"}, {3'b000, carry}, {3'b000, ec});
    chk({tag, ".zero"}, {3'b000, zero}, {3'b000, ez});
  endtask

  task automatic step(input string tag, input logic [2:0] ff, input logic [3:0] aa, input logic [3:0] bb);
    @(negedge clk);
    f = ff;
    a = aa;
    b = bb;
    model(ff, aa, bb);
    @(posedge clk);
    #1;
    chk_all(tag, exp_y, exp_c, exp_z);
  endtask

  initial begin
    logic [2:0] rf;
    logic [3:0] ra, rb;

    #2 reset = 1'b1;
    #1 chk_all("reset_init", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 chk_all("reset_hold", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step("passa_1", 3'b000, 4'b0001, 4'b0000);
    step("passa_0", 3'b000, 4'b0000, 4'b0000);
    step("passb",   3'b010, 4'b1000, 4'b0100);
    step("sub_eq",  3'b001, 4'b0001, 4'b0001);
    step("sub_brw", 3'b001, 4'b0000, 4'b0001);
    step("sub_00",  3'b001, 4'b0000, 4'b0000);
    step("add",     3'b011, 4'b0000, 4'b0100);
    step("add_wrap",3'b011, 4'b1111, 4'b0001);
    step("nand_a",  3'b100, 4'b0010, 4'b0000);
    step("nand_ff", 3'b100, 4'b1111, 4'b1111);
    step("rsv_101", 3'b101, 4'b1010, 4'b0101);
    step("rsv_110", 3'b110, 4'b1111, 4'b1111);
    step("rsv_111", 3'b111, 4'b0011, 4'b1100);

    // Asynchronous reset mid-cycle with nonzero outputs.
    step("pre_rst", 3'b011, 4'b1111, 4'b0011);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all("reset_async", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_all("reset_async_hold", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 3'b000, 4'b0110, 4'b0000);

    // Latency: input changes between edges must not reach the outputs early.
    step("lat_base", 3'b011, 4'b0010, 4'b0011);
    @(negedge clk);
    f = 3'b100;
    a = 4'b1111;
    b = 4'b1111;
    #2 chk_all("lat_hold", 4'b0101, 1'b0, 1'b0);
    model(f, a, b);
    @(posedge clk);
    #1 chk_all("lat_update", exp_y, exp_c, exp_z);

    for (int i = 0; i < 300; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rb = 4'($urandom);
      step("rand", rf, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
